// File: rtl/data_memory_pkg.sv
// Shared types and constants for the line-wide backing memory model.
// Imported by the controller and the array.
package data_memory_pkg;

    localparam int LINE_BITS   = 256;
    localparam int OFFSET_BITS = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_t;

endpackage

// File: rtl/data_memory_array.sv
// Single-port synchronous line RAM.
// The read register clears on reset; the array contents do not.
module data_memory_array
    import data_memory_pkg::*;
#(
    parameter int MEM_LINES = 512,
    localparam int IDX_W    = $clog2(MEM_LINES)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    input  logic                 we_i,
    input  logic [IDX_W-1:0]     idx_i,
    input  logic [LINE_BITS-1:0] wdata_i,
    output logic [LINE_BITS-1:0] rdata_o
);

    logic [LINE_BITS-1:0] mem [MEM_LINES];

    always_ff @(posedge clk_i) begin
        if (en_i && we_i) begin
            mem[idx_i] <= wdata_i;
        end
    end

    // Holds the last read line across writes and idle time
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_o <= '0;
        end else if (en_i && !we_i) begin
            rdata_o <= mem[idx_i];
        end
    end

endmodule

// File: rtl/data_memory.sv
// Fixed-latency line memory behind the cache refill/writeback port.
// Requests are captured on acceptance; ack pulses LATENCY edges later.
module data_memory
    import data_memory_pkg::*;
#(
    parameter int MEM_LINES = 512,
    parameter int LATENCY   = 10
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 enable_i,
    input  logic                 write_i,
    input  logic [31:0]          addr_i,
    input  logic [LINE_BITS-1:0] data_i,
    output logic                 ack_o,
    output logic [LINE_BITS-1:0] data_o
);

    localparam int IDX_W = $clog2(MEM_LINES);
    localparam int IDX_HI = OFFSET_BITS + IDX_W;

    state_t               state_q;
    state_t               state_d;
    logic [7:0]           count_q;
    logic                 write_q;
    logic [IDX_W-1:0]     idx_q;
    logic [LINE_BITS-1:0] data_q;
    logic                 last_edge;
    logic                 access;
    logic                 unused_addr;

    assign unused_addr = ^{addr_i[31:IDX_HI], addr_i[OFFSET_BITS-1:0]};
    assign last_edge   = (count_q == 8'(LATENCY - 1));
    assign ack_o       = (state_q == ACK);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        access  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (enable_i) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (last_edge) begin
                    state_d = ACK;
                    access  = 1'b1;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else if (state_q == IDLE && enable_i) begin
            count_q <= 8'd1;
        end else if (state_q == WAIT && !last_edge) begin
            count_q <= count_q + 8'd1;
        end
    end

    // Request fields are frozen for the whole transaction
    always_ff @(posedge clk_i) begin
        if (!rst_i && state_q == IDLE && enable_i) begin
            write_q <= write_i;
            idx_q   <= addr_i[IDX_HI-1:OFFSET_BITS];
            data_q  <= data_i;
        end
    end

    data_memory_array #(
        .MEM_LINES (MEM_LINES)
    ) u_array (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .en_i    (access && !rst_i),
        .we_i    (write_q),
        .idx_i   (idx_q),
        .wdata_i (data_q),
        .rdata_o (data_o)
    );

endmodule

// File: doc/data_memory.md
DATA_MEMORY -- requirements
Module: data_memory

Interface
REQ-001 SHALL have parameter MEM_LINES, default 512, number of 256-bit lines (power of two).
REQ-002 SHALL have parameter LATENCY, default 10, clock edges from request acceptance to ack (legal range 2..255).
REQ-003 SHALL have port clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port enable_i  input  1  request valid, from cache mem_enable.
REQ-006 SHALL have port write_i  input  1  1 = line write, 0 = line read.
REQ-007 SHALL have port addr_i  input  32  byte address; only bits [5+log2(MEM_LINES)-1:5] used.
REQ-008 SHALL have port data_i  input  256  write line data.
REQ-009 SHALL have port ack_o  output  1  one-cycle completion pulse.
REQ-010 SHALL have port data_o  output  256  read line data, valid from the ack cycle onward.

Function
REQ-011 SHALL implement states IDLE, WAIT, ACK.
REQ-012 In IDLE with enable_i=1 at a rising edge, SHALL capture addr_i, data_i, write_i, load counter to 1, and enter WAIT.
REQ-013 In IDLE with enable_i=0, SHALL remain in IDLE with ack_o=0.
REQ-014 In WAIT, SHALL increment the counter each edge and ignore all input changes, including enable_i deassertion.
REQ-015 At the edge where the counter equals LATENCY-1, SHALL perform the access and enter ACK.
REQ-016 The access SHALL be mem[idx] <= captured data for a write, or data_o <= mem[idx] for a read.
REQ-017 ack_o SHALL be 1 exactly while in ACK, i.e. LATENCY edges after the accepting edge, for exactly one cycle.
REQ-018 From ACK, SHALL return to IDLE unconditionally.
REQ-019 A request held high across ACK SHALL be accepted at the first IDLE edge, giving back-to-back writeback-then-refill.
REQ-020 data_o SHALL hold its last read value through writes and idle periods.
REQ-021 Address bits [4:0] and bits above the index field SHALL be ignored; aliasing is permitted.
REQ-022 A write followed by a read to the same line SHALL return the written data.

Reset
REQ-023 On rst_i=1 at an edge, SHALL force state=IDLE, counter=0, ack_o=0, data_o=0.
REQ-024 Memory contents SHALL not be cleared by reset.
REQ-025 Reset during WAIT SHALL abort the transaction: no array write, no ack.
REQ-026 Reset SHALL take priority over every other event in the same cycle.

Structure
REQ-027 Package data_memory_pkg SHALL hold the state encoding, LINE_BITS=256 and OFFSET_BITS=5.
REQ-028 The array SHALL be a sub-module data_memory_array: single-port synchronous RAM with write and read on the same edge, MEM_LINES x 256.
REQ-029 The controller (FSM, counter and capture registers) SHALL reside in data_memory.

Verification
REQ-030 Scenario: reset, then idle 5 cycles -> ack_o=0 and data_o=0 throughout.
REQ-031 Scenario: write line 0x0000_0040 with pattern 0xA5 repeated, then read the same address -> ack on edge 10 of each, data_o=0xA5 pattern.
REQ-032 Scenario: enable_i dropped and addr_i changed to 0x80 on cycle 3 of a read of 0x40 -> ack still at edge 10, data from 0x40.
REQ-033 Scenario: enable held high through ack (writeback 0x400 then refill 0x40) -> second ack exactly LATENCY+1 edges after the first.
REQ-034 Scenario: rst_i asserted at edge 5 of a write to 0x60 -> no ack; a later read of 0x60 returns the prior contents.
REQ-035 Scenario: addresses 0x40 and 0x40+MEM_LINES*32 -> both map to the same line (alias check).
